// File: rtl/axil_csr_slave.sv
// AXI4-Lite responder for a bank of 32-bit CSRs: N_CTRL read/write control
// registers followed by N_STAT read-only status words sampled from the stack.
module axil_csr_slave #(
    parameter int          ADDR_BITS    = 64,
    parameter int          N_CTRL       = 16,
    parameter int          N_STAT       = 16,
    parameter logic [31:0] CTRL_RST_VAL = 32'h0
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic [ADDR_BITS-1:0]   s_axil_awaddr,
    input  logic                   s_axil_awvalid,
    output logic                   s_axil_awready,
    input  logic [31:0]            s_axil_wdata,
    input  logic [3:0]             s_axil_wstrb,
    input  logic                   s_axil_wvalid,
    output logic                   s_axil_wready,
    output logic [1:0]             s_axil_bresp,
    output logic                   s_axil_bvalid,
    input  logic                   s_axil_bready,
    input  logic [ADDR_BITS-1:0]   s_axil_araddr,
    input  logic                   s_axil_arvalid,
    output logic                   s_axil_arready,
    output logic [31:0]            s_axil_rdata,
    output logic [1:0]             s_axil_rresp,
    output logic                   s_axil_rvalid,
    input  logic                   s_axil_rready,
    output logic [N_CTRL*32-1:0]   ctrl_regs,
    output logic [N_CTRL-1:0]      ctrl_wr_pulse,
    input  logic [N_STAT*32-1:0]   status_regs
);

    localparam int N_REGS = N_CTRL + N_STAT;
    localparam int IW     = ADDR_BITS - 2;
    localparam int IDXW   = $clog2(N_REGS);

    function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        for (int k = 0; k < 4; k++) begin
            res[8*k +: 8] = strb[k] ? new_v[8*k +: 8] : old_v[8*k +: 8];
        end
        return res;
    endfunction

    logic [IW-1:0]         awidx_q;
    logic [31:0]           wdata_q;
    logic [3:0]            wstrb_q;
    logic                  aw_held_q, w_held_q;
    logic                  bvalid_q, rvalid_q;
    logic [1:0]            bresp_q, rresp_q;
    logic [31:0]           rdata_q;
    logic [N_CTRL*32-1:0]  ctrl_q, ctrl_d;
    logic [N_CTRL-1:0]     pulse_q, pulse_d;
    logic [31:0]           regs_s [N_REGS];
    logic [IW-1:0]         rd_idx_s;
    logic                  rd_ok_s, wr_ok_s, commit_s;
    logic [31:0]           rd_data_s;
    logic                  aw_hs_s, w_hs_s, ar_hs_s;
    logic                  unused_s;

    assign unused_s       = ^{s_axil_awaddr[1:0], s_axil_araddr[1:0]};
    assign s_axil_awready = aresetn && !aw_held_q && !bvalid_q;
    assign s_axil_wready  = aresetn && !w_held_q && !bvalid_q;
    assign s_axil_arready = aresetn && !rvalid_q;
    assign aw_hs_s        = s_axil_awvalid && s_axil_awready;
    assign w_hs_s         = s_axil_wvalid && s_axil_wready;
    assign ar_hs_s        = s_axil_arvalid && s_axil_arready;
    assign commit_s       = aw_held_q && w_held_q;

    assign s_axil_bvalid  = bvalid_q;
    assign s_axil_bresp   = bresp_q;
    assign s_axil_rvalid  = rvalid_q;
    assign s_axil_rdata   = rdata_q;
    assign s_axil_rresp   = rresp_q;
    assign ctrl_regs      = ctrl_q;
    assign ctrl_wr_pulse  = pulse_q;

    // Flat register map: control words first, status words after them.
    for (genvar i = 0; i < N_CTRL; i++) begin : g_map_ctrl
        assign regs_s[i] = ctrl_q[32*i +: 32];
    end
    for (genvar j = 0; j < N_STAT; j++) begin : g_map_stat
        assign regs_s[N_CTRL+j] = status_regs[32*j +: 32];
    end

    assign rd_idx_s = s_axil_araddr[ADDR_BITS-1:2];
    assign rd_ok_s  = (rd_idx_s < IW'(N_REGS));
    assign wr_ok_s  = (awidx_q < IW'(N_REGS));

    // Read mux; out-of-range words return a recognisable poison pattern.
    always_comb begin
        rd_data_s = 32'hDEAD_BEEF;
        if (rd_ok_s) begin
            rd_data_s = regs_s[rd_idx_s[IDXW-1:0]];
        end else begin
            rd_data_s = 32'hDEAD_BEEF;
        end
    end

    // Byte-merged control update and per-register strobe on commit.
    always_comb begin
        ctrl_d  = ctrl_q;
        pulse_d = '0;
        if (commit_s) begin
            for (int i = 0; i < N_CTRL; i++) begin
                if (awidx_q == IW'(i)) begin
                    ctrl_d[32*i +: 32] = apply_strb(ctrl_q[32*i +: 32], wdata_q, wstrb_q);
                    pulse_d[i]         = 1'b1;
                end else begin
                    ctrl_d[32*i +: 32] = ctrl_q[32*i +: 32];
                end
            end
        end else begin
            ctrl_d = ctrl_q;
        end
    end

    // Write-channel holding registers, response and read-channel state.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            awidx_q   <= '0;
            wdata_q   <= 32'h0;
            wstrb_q   <= 4'h0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            rvalid_q  <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= 32'h0;
            ctrl_q    <= {N_CTRL{CTRL_RST_VAL}};
            pulse_q   <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            pulse_q <= pulse_d;
            if (commit_s) begin
                aw_held_q <= 1'b0;
                w_held_q  <= 1'b0;
                bvalid_q  <= 1'b1;
                bresp_q   <= wr_ok_s ? 2'b00 : 2'b10;
            end else begin
                if (aw_hs_s) begin
                    aw_held_q <= 1'b1;
                    awidx_q   <= s_axil_awaddr[ADDR_BITS-1:2];
                end
                if (w_hs_s) begin
                    w_held_q <= 1'b1;
                    wdata_q  <= s_axil_wdata;
                    wstrb_q  <= s_axil_wstrb;
                end
                if (bvalid_q && s_axil_bready) begin
                    bvalid_q <= 1'b0;
                end
            end
            if (ar_hs_s) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_data_s;
                rresp_q  <= rd_ok_s ? 2'b00 : 2'b10;
            end else if (rvalid_q && s_axil_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axil_csr_slave.sv
// Directed bench for axil_csr_slave: write ordering, strobes, backpressure,
// status reads, decode errors, same-edge read/write and mid-transaction reset.
module tb_axil_csr_slave;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic [63:0]   awaddr, araddr;
    logic          awvalid, wvalid, bready, arvalid, rready;
    logic          awready, wready, bvalid, arready, rvalid;
    logic [31:0]   wdata, rdata;
    logic [3:0]    wstrb;
    logic [1:0]    bresp, rresp;
    logic [511:0]  ctrl_regs;
    logic [15:0]   ctrl_wr_pulse;
    logic [511:0]  status_regs;

    int checks = 0;
    int errors = 0;

    always #5 aclk = ~aclk;

    axil_csr_slave dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .s_axil_awaddr  (awaddr),
        .s_axil_awvalid (awvalid),
        .s_axil_awready (awready),
        .s_axil_wdata   (wdata),
        .s_axil_wstrb   (wstrb),
        .s_axil_wvalid  (wvalid),
        .s_axil_wready  (wready),
        .s_axil_bresp   (bresp),
        .s_axil_bvalid  (bvalid),
        .s_axil_bready  (bready),
        .s_axil_araddr  (araddr),
        .s_axil_arvalid (arvalid),
        .s_axil_arready (arready),
        .s_axil_rdata   (rdata),
        .s_axil_rresp   (rresp),
        .s_axil_rvalid  (rvalid),
        .s_axil_rready  (rready),
        .ctrl_regs      (ctrl_regs),
        .ctrl_wr_pulse  (ctrl_wr_pulse),
        .status_regs    (status_regs)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    initial begin
        aresetn = 1'b0;
        awaddr = 64'h0; araddr = 64'h0; wdata = 32'h0; wstrb = 4'h0;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
        status_regs = 512'h0;
        status_regs[31:0]  = 32'hCAFE_0001;
        status_regs[63:32] = 32'h5A5A_0017;
        #12;
        chk("rst_awready", {31'h0, awready}, 32'h0);
        chk("rst_wready",  {31'h0, wready},  32'h0);
        chk("rst_arready", {31'h0, arready}, 32'h0);
        chk("rst_bvalid",  {31'h0, bvalid},  32'h0);
        chk("rst_rvalid",  {31'h0, rvalid},  32'h0);
        chk("rst_rdata",   rdata, 32'h0);
        chk("rst_ctrl",    {31'h0, (ctrl_regs == 512'h0)}, 32'h1);
        chk("rst_pulse",   {16'h0, ctrl_wr_pulse}, 32'h0);
        step();
        aresetn = 1'b1;
        #1;
        chk("awready_up", {31'h0, awready}, 32'h1);

        // AW and W together, reg 2
        awaddr = 64'h08; awvalid = 1'b1; wdata = 32'h1234_5678; wstrb = 4'hF; wvalid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        chk("t1_no_b_yet", {31'h0, bvalid}, 32'h0);
        step();
        chk("t1_bvalid", {31'h0, bvalid}, 32'h1);
        chk("t1_bresp",  {30'h0, bresp},  32'h0);
        chk("t1_reg2",   ctrl_regs[95:64], 32'h1234_5678);
        chk("t1_pulse",  {16'h0, ctrl_wr_pulse}, 32'h0004);
        bready = 1'b1;
        step();
        bready = 1'b0;
        chk("t1_bdone",  {31'h0, bvalid}, 32'h0);
        chk("t1_pulse0", {16'h0, ctrl_wr_pulse}, 32'h0);

        // W first, AW three cycles later, partial strobe
        wdata = 32'hAABB_CCDD; wstrb = 4'b0101; wvalid = 1'b1;
        step();
        wvalid = 1'b0;
        chk("t2_wready_held", {31'h0, wready}, 32'h0);
        chk("t2_awready",     {31'h0, awready}, 32'h1);
        step();
        step();
        chk("t2_wready_still", {31'h0, wready}, 32'h0);
        awaddr = 64'h08; awvalid = 1'b1;
        step();
        awvalid = 1'b0;
        step();
        chk("t2_bvalid", {31'h0, bvalid}, 32'h1);
        chk("t2_reg2",   ctrl_regs[95:64], 32'h12BB_56DD);

        // B backpressure with a new write waiting
        awaddr = 64'h0C; awvalid = 1'b1; wdata = 32'h0000_0055; wstrb = 4'hF; wvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t3_bvalid_hold", {31'h0, bvalid}, 32'h1);
            chk("t3_bresp_hold",  {30'h0, bresp}, 32'h0);
            chk("t3_awready_low", {31'h0, awready}, 32'h0);
            chk("t3_wready_low",  {31'h0, wready}, 32'h0);
        end
        bready = 1'b1;
        step();
        bready = 1'b0;
        chk("t3_bdone",    {31'h0, bvalid}, 32'h0);
        chk("t3_awready",  {31'h0, awready}, 32'h1);
        chk("t3_reg3_old", ctrl_regs[127:96], 32'h0);
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        step();
        chk("t3_bvalid2", {31'h0, bvalid}, 32'h1);
        chk("t3_reg3",    ctrl_regs[127:96], 32'h0000_0055);
        chk("t3_pulse",   {16'h0, ctrl_wr_pulse}, 32'h0008);
        bready = 1'b1;
        step();
        bready = 1'b0;

        // Status read with R backpressure
        araddr = 64'h40; arvalid = 1'b1;
        chk("t4_arready", {31'h0, arready}, 32'h1);
        step();
        arvalid = 1'b0;
        chk("t4_rvalid", {31'h0, rvalid}, 32'h1);
        chk("t4_rdata",  rdata, 32'hCAFE_0001);
        chk("t4_rresp",  {30'h0, rresp}, 32'h0);
        status_regs[31:0] = 32'h1234_0000;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t4_rvalid_hold", {31'h0, rvalid}, 32'h1);
            chk("t4_arready_low", {31'h0, arready}, 32'h0);
            chk("t4_rdata_hold",  rdata, 32'hCAFE_0001);
        end
        rready = 1'b1;
        step();
        rready = 1'b0;
        chk("t4_rdone", {31'h0, rvalid}, 32'h0);

        // Out-of-range write and read
        awaddr = 64'h80; awvalid = 1'b1; wdata = 32'hFFFF_FFFF; wstrb = 4'hF; wvalid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        step();
        chk("t5_bvalid",  {31'h0, bvalid}, 32'h1);
        chk("t5_bresp",   {30'h0, bresp}, 32'h2);
        chk("t5_pulse",   {16'h0, ctrl_wr_pulse}, 32'h0);
        chk("t5_reg0",    ctrl_regs[31:0], 32'h0);
        chk("t5_reg2",    ctrl_regs[95:64], 32'h12BB_56DD);
        chk("t5_reg15",   ctrl_regs[511:480], 32'h0);
        bready = 1'b1;
        step();
        bready = 1'b0;
        araddr = 64'h80; arvalid = 1'b1;
        step();
        arvalid = 1'b0;
        chk("t5_rdata", rdata, 32'hDEAD_BEEF);
        chk("t5_rresp", {30'h0, rresp}, 32'h2);
        rready = 1'b1;
        step();
        rready = 1'b0;

        // Write to a read-only word
        awaddr = 64'h44; awvalid = 1'b1; wdata = 32'h0BAD_0BAD; wstrb = 4'hF; wvalid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        step();
        chk("t6_bvalid", {31'h0, bvalid}, 32'h1);
        chk("t6_bresp",  {30'h0, bresp}, 32'h0);
        chk("t6_pulse",  {16'h0, ctrl_wr_pulse}, 32'h0);
        bready = 1'b1;
        step();
        bready = 1'b0;
        araddr = 64'h44; arvalid = 1'b1;
        step();
        arvalid = 1'b0;
        chk("t6_rdata", rdata, 32'h5A5A_0017);
        chk("t6_rresp", {30'h0, rresp}, 32'h0);
        rready = 1'b1;
        step();
        rready = 1'b0;

        // Same-edge commit and read of reg 0
        awaddr = 64'h00; awvalid = 1'b1; wdata = 32'h1; wstrb = 4'hF; wvalid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        step();
        bready = 1'b1;
        step();
        bready = 1'b0;
        chk("t7_reg0_old", ctrl_regs[31:0], 32'h1);
        awaddr = 64'h00; awvalid = 1'b1; wdata = 32'h2; wvalid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 64'h00; arvalid = 1'b1;
        step();
        arvalid = 1'b0;
        chk("t7_rdata_old", rdata, 32'h1);
        chk("t7_reg0_new",  ctrl_regs[31:0], 32'h2);
        chk("t7_bvalid",    {31'h0, bvalid}, 32'h1);
        rready = 1'b1; bready = 1'b1;
        step();
        rready = 1'b0; bready = 1'b0;
        araddr = 64'h00; arvalid = 1'b1;
        step();
        arvalid = 1'b0;
        chk("t7_rdata_new", rdata, 32'h2);
        rready = 1'b1;
        step();
        rready = 1'b0;

        // Reset while an address is held
        awaddr = 64'h10; awvalid = 1'b1;
        step();
        awvalid = 1'b0;
        chk("t8_aw_held", {31'h0, awready}, 32'h0);
        aresetn = 1'b0;
        #1;
        chk("t8_rst_ctrl",    {31'h0, (ctrl_regs == 512'h0)}, 32'h1);
        chk("t8_rst_awready", {31'h0, awready}, 32'h0);
        chk("t8_rst_wready",  {31'h0, wready}, 32'h0);
        step();
        aresetn = 1'b1;
        #1;
        chk("t8_awready", {31'h0, awready}, 32'h1);
        chk("t8_wready",  {31'h0, wready}, 32'h1);
        wdata = 32'h77; wstrb = 4'hF; wvalid = 1'b1;
        step();
        wvalid = 1'b0;
        step();
        step();
        chk("t8_no_bvalid", {31'h0, bvalid}, 32'h0);
        chk("t8_reg4",      ctrl_regs[159:128], 32'h0);
        chk("t8_awready2",  {31'h0, awready}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
